sipo_frame_ctrl: RTL and testbench

//  Controller that sequences a WIDTH-bit serial-in/parallel-out shift register.

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_frame_ctrl_if.sv | 20 ++
 rtl/sipo_shift_reg.sv | 26 ++
 rtl/sipo_frame_ctrl.sv | 123 ++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared types and limits for the SIPO frame controller.
package sipo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sipo_state_e;

   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Word handoff channel: holding register towards the consumer.
interface sipo_frame_ctrl_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             word_ready;

   modport master (
      output word_out,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_out,
      input  word_valid,
      output word_ready
   );
endinterface

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in/parallel-out register, new bits enter at the MSB.
module sipo_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic             shift_en,
   input  logic             bit_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] q_q;

   // load wipes the history of any earlier partial frame
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else if (load_en) begin
         q_q <= {bit_i, {(WIDTH-1){1'b0}}};
      end else if (shift_en) begin
         q_q <= {bit_i, q_q[WIDTH-1:1]};
      end
   end

   assign q_o = q_q;
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames a strobed serial stream into words and hands them off.
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bit_in,
   input  logic          bit_valid,
   input  logic          frame_start,
   input  logic          clr_overrun,
   output logic          busy,
   output logic [CW-1:0] bit_cnt,
   output logic          overrun,
   output logic          frame_err,
   sipo_frame_ctrl_if.master wd
);
   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("sipo_frame_ctrl: WIDTH out of range");
   end

   localparam logic [CW-1:0] FULL = CW'(WIDTH);

   sipo_state_e      state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] word_q;
   logic             vld_q;
   logic             ovr_q;
   logic             ferr_q;
   logic [WIDTH-1:0] sreg;
   logic             start;
   logic             shift_en;
   logic             accept;
   logic             drop;
   logic [CW-1:0]    cnt_inc;

   assign start    = bit_valid & frame_start;
   assign shift_en = bit_valid & ~frame_start
                   & (state_q == SHIFT);
   assign accept   = vld_q & wd.word_ready;
   assign drop     = (state_q == DONE) & vld_q
                   & ~wd.word_ready;
   assign cnt_inc  = cnt_q + 1'b1;

   sipo_shift_reg #(.WIDTH(WIDTH)) u_sreg (
      .clk      (clk),
      .rst      (rst),
      .load_en  (start),
      .shift_en (shift_en),
      .bit_i    (bit_in),
      .q_o      (sreg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         vld_q   <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SHIFT;
                  cnt_q   <= CW'(1);
               end else begin
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               if (start) begin
                  cnt_q  <= CW'(1);
                  ferr_q <= 1'b1;
               end else if (bit_valid) begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == FULL) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  state_q <= SHIFT;
                  cnt_q   <= CW'(1);
               end else begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase

         // handoff: a pop in the same cycle frees the slot
         if (state_q == DONE && (!vld_q || accept)) begin
            word_q <= sreg;
            vld_q  <= 1'b1;
         end else if (accept) begin
            vld_q  <= 1'b0;
         end

         if (drop) begin
            ovr_q <= 1'b1;
         end else if (clr_overrun) begin
            ovr_q <= 1'b0;
         end
      end
   end

   assign busy          = (state_q == SHIFT);
   assign bit_cnt       = cnt_q;
   assign overrun       = ovr_q;
   assign frame_err     = ferr_q;
   assign wd.word_out   = word_q;
   assign wd.word_valid = vld_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with a per-cycle frame model.
module tb_sipo_frame_ctrl;
   localparam int W  = 4;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          bit_in;
   logic          bit_valid;
   logic          frame_start;
   logic          clr_overrun;
   logic          busy;
   logic [CW-1:0] bit_cnt;
   logic          overrun;
   logic          frame_err;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   sipo_frame_ctrl_if #(.WIDTH(W)) wd ();

   sipo_frame_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .frame_start (frame_start),
      .clr_overrun (clr_overrun),
      .busy        (busy),
      .bit_cnt     (bit_cnt),
      .overrun     (overrun),
      .frame_err   (frame_err),
      .wd          (wd.master)
   );

   always #5 clk = ~clk;

   // model: bits gathered so far, completed word waiting, one-slot hold
   int         m_n = 0;
   logic [W-1:0] m_acc = '0;
   bit         m_full = 0;
   logic [W-1:0] m_hold = '0;
   bit         m_hv = 0;
   bit         m_ovr = 0;
   bit         m_ferr = 0;

   logic [W-1:0] got_q[$];

   initial forever begin
      @(posedge clk);
      if (wd.word_valid === 1'b1 && wd.word_ready)
         got_q.push_back(wd.word_out);
      if (rst) begin
         m_n = 0; m_acc = '0; m_full = 0;
         m_hold = '0; m_hv = 0; m_ovr = 0; m_ferr = 0;
      end else begin
         m_ferr = 0;
         if (m_full) begin
            if (!m_hv || wd.word_ready) begin
               m_hold = m_acc;
               m_hv = 1;
            end else begin
               m_ovr = 1;
            end
         end else if (m_hv && wd.word_ready) begin
            m_hv = 0;
         end
         if (clr_overrun && !(m_full && m_hv && !wd.word_ready))
            m_ovr = 0;
         if (m_full || m_n == 0) begin
            m_full = 0;
            m_n = 0;
            if (bit_valid && frame_start) begin
               m_acc = '0;
               m_acc[0] = bit_in;
               m_n = 1;
            end
         end else if (bit_valid && frame_start) begin
            m_ferr = 1;
            m_acc = '0;
            m_acc[0] = bit_in;
            m_n = 1;
         end else if (bit_valid) begin
            m_acc[m_n] = bit_in;
            m_n = m_n + 1;
            if (m_n == W) m_full = 1;
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("word_valid", 32'(wd.word_valid), 32'(m_hv));
         check("word_out", 32'(wd.word_out), 32'(m_hold));
         check("overrun", 32'(overrun), 32'(m_ovr));
         check("frame_err", 32'(frame_err), 32'(m_ferr));
         check("bit_cnt", 32'(bit_cnt), 32'(m_n));
         check("busy", 32'(busy), 32'(m_n > 0 && !m_full));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      bit_valid = 0; frame_start = 0; bit_in = 0;
      repeat (n) tick();
   endtask

   task automatic send_bit(logic b, logic fs, int gap);
      bit_valid = 1; frame_start = fs; bit_in = b;
      tick();
      bit_valid = 0; frame_start = 0; bit_in = 0;
      repeat (gap) tick();
   endtask

   task automatic send_word(logic [W-1:0] w, int gap);
      for (int i = 0; i < W; i++)
         send_bit(w[i], i == 0, gap);
   endtask

   initial begin
      rst = 1; bit_in = 0; bit_valid = 0;
      frame_start = 0; clr_overrun = 0;
      wd.word_ready = 1;
      repeat (2) tick();
      chk_en = 1;
      check("rst_valid", 32'(wd.word_valid), 32'd0);
      check("rst_cnt", 32'(bit_cnt), 32'd0);
      rst = 0;
      tick();

      // 1: bits 1,0,1,1
      send_bit(1, 1, 0);
      send_bit(0, 0, 0);
      send_bit(1, 0, 0);
      send_bit(1, 0, 0);
      check("t1_cnt_done", 32'(bit_cnt), 32'd4);
      check("t1_valid_early", 32'(wd.word_valid), 32'd0);
      idle(1);
      check("t1_word", 32'(wd.word_out), 32'hD);
      check("t1_valid", 32'(wd.word_valid), 32'd1);
      idle(1);
      check("t1_valid_drop", 32'(wd.word_valid), 32'd0);
      check("t1_cnt_idle", 32'(bit_cnt), 32'd0);

      // 2: overrun with consumer stalled
      wd.word_ready = 0;
      send_word(4'hA, 0);
      idle(2);
      send_word(4'h5, 0);
      idle(2);
      check("t2_word", 32'(wd.word_out), 32'hA);
      check("t2_ovr", 32'(overrun), 32'd1);
      clr_overrun = 1;
      tick();
      clr_overrun = 0;
      check("t2_ovr_clr", 32'(overrun), 32'd0);
      wd.word_ready = 1;
      idle(2);

      // 3: restart mid-frame
      send_bit(1, 1, 0);
      send_bit(1, 0, 0);
      send_bit(0, 1, 0);
      check("t3_ferr", 32'(frame_err), 32'd1);
      check("t3_cnt", 32'(bit_cnt), 32'd1);
      send_bit(0, 0, 0);
      check("t3_ferr_pulse", 32'(frame_err), 32'd0);
      send_bit(1, 0, 0);
      send_bit(1, 0, 0);
      idle(1);
      check("t3_word", 32'(wd.word_out), 32'hC);
      idle(2);

      // 4: gapped strobes
      send_bit(1, 1, 2);
      check("t4_cnt1", 32'(bit_cnt), 32'd1);
      send_bit(0, 0, 2);
      check("t4_cnt2", 32'(bit_cnt), 32'd2);
      send_bit(0, 0, 2);
      send_bit(1, 0, 0);
      idle(1);
      check("t4_word", 32'(wd.word_out), 32'h9);
      idle(2);

      // 5: new frame in the DONE cycle while the held word pops
      wd.word_ready = 0;
      send_word(4'h3, 0);
      idle(2);
      got_q.delete();
      send_word(4'hA, 0);
      wd.word_ready = 1;
      send_word(4'h5, 0);
      idle(3);
      check("t5_count", 32'(got_q.size()), 32'd3);
      if (got_q.size() == 3) begin
         check("t5_w0", 32'(got_q[0]), 32'h3);
         check("t5_w1", 32'(got_q[1]), 32'hA);
         check("t5_w2", 32'(got_q[2]), 32'h5);
      end
      check("t5_ovr", 32'(overrun), 32'd0);

      // 6: reset mid-frame
      wd.word_ready = 0;
      send_bit(1, 1, 0);
      send_bit(1, 0, 0);
      send_bit(1, 0, 0);
      rst = 1;
      tick();
      rst = 0;
      check("t6_cnt", 32'(bit_cnt), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_valid", 32'(wd.word_valid), 32'd0);
      wd.word_ready = 1;
      send_word(4'h6, 0);
      idle(1);
      check("t6_word", 32'(wd.word_out), 32'h6);
      idle(2);

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
